// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and fault helper for the data memory controller
//
// Purpose: access-size encodings, controller state encoding and the request
//          fault predicate used by data_memory_ctrl.
// Contents: SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD, state_t {IDLE, WAIT, RESP},
//           access_fault(size, addr, aw).
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // A request is rejected for a reserved size, a misaligned half/word,
  // or any address bit set above the implemented word-index range.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [31:0] addr,
                                        input int unsigned aw);
    logic misaligned;
    misaligned = ((size == SIZE_HALF) && addr[0]) ||
                 ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
    return (size == SIZE_RSVD) || misaligned || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - byte-lane enables, store merge and load extension
//
// Purpose: combinational lane steering for little-endian sub-word accesses.
// Ports:
//   size         in  2   access size (mem_pkg SIZE_*)
//   offset       in  2   byte offset within the word (addr[1:0])
//   is_unsigned  in  1   1 = zero-extend loads, 0 = sign-extend
//   wdata        in  32  right-aligned store data
//   rdata_word   in  32  current contents of the addressed word
//   byte_en      out 4   lanes written by a store (0 for reserved size)
//   wdata_merged out 32  new word: store data in enabled lanes, old bytes elsewhere
//   load_data    out 32  extracted and extended load result
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_merged,
  output logic [31:0] load_data
);

  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_word[{offset, 3'b000} +: 8];
  assign half_sel = rdata_word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    load_data = rdata_word;
    case (size)
      SIZE_BYTE: begin
        byte_en   = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        load_data = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        load_data = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SIZE_WORD: begin
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        load_data = rdata_word;
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase

    wdata_merged = rdata_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) wdata_merged[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - handshaked byte/half/word data memory with latency and faults
//
// Purpose: MEM-stage data RAM front end. Captures one request at a time,
//          waits LATENCY cycles, performs the array access and returns a
//          one-cycle response pulse. Faulting requests respond after one
//          cycle with no memory side effect.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_fault                       registered response
//   dbg_addr/dbg_rdata       side-effect-free backdoor word read
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [31:0]           dbg_rdata
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [2:0] LAT   = 3'(LATENCY);

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [2:0]  cnt;
  logic        cap_write;
  logic        cap_unsigned;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic                  accept;
  logic                  cap_fault;
  logic                  access_now;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic [31:0]           rdata_word;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_merged;
  logic [31:0]           load_data;

  assign req_ready  = !rst && (state != WAIT);
  assign accept     = req_valid && req_ready;
  assign cap_fault  = access_fault(cap_size, cap_addr, ADDR_WIDTH);
  assign cap_idx    = cap_addr[ADDR_WIDTH+1:2];
  assign rdata_word = mem[cap_idx];
  assign access_now = (state == WAIT) && (cnt == 3'd1) && !cap_fault;
  assign dbg_rdata  = mem[dbg_addr];

  byte_lane_align u_align (
    .size         (cap_size),
    .offset       (cap_addr[1:0]),
    .is_unsigned  (cap_unsigned),
    .wdata        (cap_wdata),
    .rdata_word   (rdata_word),
    .byte_en      (byte_en),
    .wdata_merged (wdata_merged),
    .load_data    (load_data)
  );

  // Whole-word write of the merged word; rst gates it so a store pending
  // in WAIT is dropped when reset lands on its commit edge.
  always_ff @(posedge clk) begin
    if (!rst && access_now && cap_write && (byte_en != 4'b0000)) begin
      mem[cap_idx] <= wdata_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            cap_write    <= req_write;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_addr     <= req_addr;
            cap_wdata    <= req_wdata;
            cnt          <= LAT;
            state        <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // A faulting request leaves after a single WAIT cycle.
          if (cap_fault || (cnt == 3'd1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= cap_fault;
            resp_rdata <= (cap_fault || cap_write) ? 32'd0 : load_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - scoreboard bench for data_memory_ctrl
module tb_data_memory_ctrl;

  localparam int AW  = 12;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_rdata;

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .dbg_addr     (dbg_addr),
    .dbg_rdata    (dbg_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mdl [0:16383];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mword(input int idx);
    return {mdl[4*idx+3], mdl[4*idx+2], mdl[4*idx+1], mdl[4*idx]};
  endfunction

  // Reference: memory is a flat little-endian byte array.
  task automatic model(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic f);
    int n;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    f  = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'h4000);
    rd = 32'd0;
    v  = 32'd0;
    if (!f) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[a+i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a+i];
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with
  // req_valid still high so back-to-back issue is possible.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input bit commit);
    int   n;
    exp_t e;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    req_valid    = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
    end else if (commit) begin
      model(w, sz, u, a, d, e.rdata, e.fault);
      e.cyc = cyc + 1 + (e.fault ? 1 : LAT);
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drop();
    req_valid = 1'b0;
  endtask

  task automatic op(input logic w, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] d);
    issue(w, sz, u, a, d, 1'b1);
    drop();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_pending", sbq.size(), 0);
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: resp_valid=1 with no outstanding request (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_fault", 32'(resp_fault), 32'(e.fault));
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          idx;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    dbg_addr     = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Fill the working region so every later load reads defined data.
    for (int i = 0; i < 64; i++) op(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);
    drain();

    // Directed sequence.
    op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    op(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0080);
    op(1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
    op(1'b0, 2'd0, 1'b1, 32'h11, 32'd0);
    op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234);
    op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    op(1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
    drain();
    dbg_addr = AW'(4);
    #1;
    chk("dbg_idx4", dbg_rdata, 32'h1234_80EF);

    // Faults.
    op(1'b0, 2'd2, 1'b0, 32'h12, 32'd0);
    op(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_5555);
    op(1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
    op(1'b1, 2'd3, 1'b0, 32'h10, 32'h1111_1111);
    op(1'b1, 2'd2, 1'b0, 32'h4000, 32'h7777_7777);
    drain();
    dbg_addr = AW'(4);
    #1;
    chk("fault_dbg_idx4", dbg_rdata, 32'h1234_80EF);
    dbg_addr = AW'(0);
    #1;
    chk("fault_dbg_idx0", dbg_rdata, mword(0));

    // Back-to-back loads with req_valid held high.
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 1'b1);
    drop();
    drain();

    // Reset during WAIT drops the pending store.
    op(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
    drain();
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0);
    drop();
    rst = 1'b1;
    #1;
    chk("wait_rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("wait_rst_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("after_rst_req_ready", 32'(req_ready), 32'd1);
    repeat (5) @(negedge clk);
    dbg_addr = AW'(8);
    #1;
    chk("wait_rst_dbg_idx8", dbg_rdata, 32'h1122_3344);
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 32'h4000 + 32'($urandom_range(0, 32'h3FFF_C000));
      else                           a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        a[0] = 1'b0;
        if (sz == 2'd2) a[1] = 1'b0;
      end
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
      if ($urandom_range(0, 2) != 0) drop();
      if ($urandom_range(0, 7) == 0) begin
        drop();
        drain();
        idx = $urandom_range(0, 63);
        dbg_addr = AW'(idx);
        #1;
        chk("rand_dbg", dbg_rdata, mword(idx));
      end
    end
    drop();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
